// File: rtl/mem_access.sv
// mem_access: MEM-stage responder that runs the EX memory request on a req/gnt/rvalid bus,
// formats load data and forwards the write-back triple, stalling while an access is open.
module mem_access #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  EX_rd,
  input  logic [31:0] EX_x_rd,
  input  logic        EX_x_rd_vld,
  input  logic [31:0] EX_MEMaddr,
  input  logic [3:0]  EX_MEMrden,
  input  logic        EX_MEMrden_SEXT,
  input  logic [3:0]  EX_MEMwren,
  input  logic [31:0] EX_MEMwrdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        MEM_stall,
  output logic [4:0]  MEM_rd,
  output logic [31:0] MEM_x_rd,
  output logic        MEM_x_rd_vld,
  output logic        MEM_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
  state_t state, state_nx;
  logic        a_sext, a_vld;
  logic [4:0]  a_rd;
  logic [31:0] cnt;
  logic        memreq, legal, busy, done, tmo;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic        unused_addr;

  function automatic logic mask_ok(input logic [3:0] m);
    return m inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  assign unused_addr = ^EX_MEMaddr[1:0];
  assign memreq = (EX_MEMrden != 4'b0) || (EX_MEMwren != 4'b0);
  assign legal  = !((EX_MEMrden != 4'b0) && (EX_MEMwren != 4'b0)) && mask_ok(EX_MEMrden) && mask_ok(EX_MEMwren);
  assign busy   = state != IDLE;
  assign done   = (state == REQ && dbus_gnt && (dbus_we || dbus_rvalid)) || (state == WAIT_R && dbus_rvalid);
  assign tmo    = (TIMEOUT != 0) && busy && !done && (cnt == TIMEOUT - 1);

  // For loads the byte enables are the captured read mask
  assign ld_b    = dbus_be[0] ? dbus_rdata[7:0] : dbus_be[1] ? dbus_rdata[15:8] :
                   dbus_be[2] ? dbus_rdata[23:16] : dbus_rdata[31:24];
  assign ld_h    = dbus_be[0] ? dbus_rdata[15:0] : dbus_rdata[31:16];
  assign ld_data = (&dbus_be) ? dbus_rdata :
                   (dbus_be == 4'b0011 || dbus_be == 4'b1100) ? {{16{a_sext & ld_h[15]}}, ld_h} :
                   {{24{a_sext & ld_b[7]}}, ld_b};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb
    state_nx = (state == IDLE) ? ((memreq && legal) ? REQ : IDLE) :
               (done || tmo) ? IDLE :
               (state == REQ && dbus_gnt) ? WAIT_R : state;

  always_comb begin
    dbus_req  = (state == REQ) && !tmo;
    MEM_stall = rst_n && (((state == IDLE) && memreq && legal) || (busy && !done && !tmo));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dbus_we      <= 1'b0;
      dbus_addr    <= '0;
      dbus_be      <= '0;
      dbus_wdata   <= '0;
      a_sext       <= 1'b0;
      a_vld        <= 1'b0;
      a_rd         <= '0;
      cnt          <= '0;
      MEM_rd       <= '0;
      MEM_x_rd     <= '0;
      MEM_x_rd_vld <= 1'b0;
      MEM_err      <= 1'b0;
    end else begin
      cnt          <= busy ? cnt + 32'd1 : 32'd0;
      MEM_x_rd_vld <= 1'b0;
      MEM_err      <= 1'b0;
      if (!busy && !memreq) begin
        MEM_rd       <= EX_rd;
        MEM_x_rd     <= EX_x_rd;
        MEM_x_rd_vld <= EX_x_rd_vld;
      end else if (!busy && legal) begin
        dbus_we    <= EX_MEMwren != 4'b0;
        dbus_addr  <= {EX_MEMaddr[31:2], 2'b00};
        dbus_be    <= (EX_MEMwren != 4'b0) ? EX_MEMwren : EX_MEMrden;
        dbus_wdata <= EX_MEMwrdata;
        a_sext     <= EX_MEMrden_SEXT;
        a_vld      <= EX_x_rd_vld;
        a_rd       <= EX_rd;
      end else if (!busy || tmo) begin
        MEM_err <= 1'b1;
      end else if (done && !dbus_we) begin
        MEM_rd       <= a_rd;
        MEM_x_rd     <= ld_data;
        MEM_x_rd_vld <= a_vld;
      end
    end
endmodule
